// File: rtl/exe_mem_pkg.sv
// rtl/exe_mem_pkg.sv - shared types, state encoding and default widths for the EX/MEM stage
package exe_mem_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_PC_W   = 12;
  localparam int DEF_REG_W  = 6;

  typedef struct packed {
    logic mem2reg;
    logic ctrl_regwr;
    logic memrd;
    logic memwr;
    logic branch;
  } em_ctrl_t;

  localparam int CTRL_W = $bits(em_ctrl_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Control bits must never reach the memory stage without a valid entry.
  function automatic em_ctrl_t gate_ctrl(input em_ctrl_t ctrl, input logic valid);
    return valid ? ctrl : '0;
  endfunction

endpackage

// File: rtl/exe_mem_stage_skid.sv
// rtl/exe_mem_stage_skid.sv - generic two-entry valid/ready skid buffer (pipe_skid_buf)
module pipe_skid_buf
  import exe_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready
);

  skid_state_t  state_q;
  skid_state_t  state_d;
  logic         ready_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;
  logic         load_main;
  logic         load_skid;
  logic         skid_to_main;

  // Ready comes straight from a flop so downstream ready never reaches upstream combinationally.
  assign s_tready = ready_q;
  assign m_tvalid = (state_q != EMPTY);
  assign m_tdata  = main_q;
  assign in_fire  = s_tvalid & ready_q;
  assign out_fire = m_tvalid & m_tready;

  // Next-state and datapath steering; flush empties the buffer and drops any same-cycle input.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d      = ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register and registered ready; ready stays low through reset and rises one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
    end
  end

  // Payload storage; MAIN holds its last value when the buffer drains or flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= s_tdata;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= s_tdata;
      end
    end
  end

endmodule

// File: rtl/exe_mem_stage.sv
// rtl/exe_mem_stage.sv - EX/MEM pipeline register with skid buffering; EXE_MEM_FWD_EN adds EX bypass outputs
module exe_mem_stage
  import exe_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              e_valid,
  output logic              e_ready,
  input  logic              e_mem2reg,
  input  logic              e_ctrl_regwr,
  input  logic              e_memrd,
  input  logic              e_memwr,
  input  logic              e_branch,
  input  logic              e_zero,
  input  logic [PC_W-1:0]   e_pc_out,
  input  logic [DATA_W-1:0] e_alu_out,
  input  logic [DATA_W-1:0] e_read_data2,
  input  logic [REG_W-1:0]  e_wr_reg,
  output logic              em_valid,
  input  logic              m_ready,
  output logic              em_mem2reg,
  output logic              em_ctrl_regwr,
  output logic              em_memrd,
  output logic              em_memwr,
  output logic              em_branch,
  output logic              em_zero,
  output logic              em_br_taken,
  output logic [PC_W-1:0]   em_pc_out,
  output logic [DATA_W-1:0] em_alu_out,
  output logic [DATA_W-1:0] em_read_data2,
  output logic [REG_W-1:0]  em_wr_reg
`ifdef EXE_MEM_FWD_EN
  ,
  output logic              em_fwd_en,
  output logic [REG_W-1:0]  em_fwd_reg,
  output logic [DATA_W-1:0] em_fwd_data
`endif
);

  typedef struct packed {
    em_ctrl_t            ctrl;
    logic                br_taken;
    logic                zero;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   alu;
    logic [DATA_W-1:0]   rd2;
    logic [REG_W-1:0]    wr_reg;
  } em_entry_t;

  localparam int PAY_W = $bits(em_entry_t);

  em_entry_t in_entry;
  em_entry_t main_entry;
  em_ctrl_t  ctrl_out;

  // Pack the execute-stage fields; branch outcome is resolved here so it travels with the entry.
  always_comb begin
    in_entry                 = '0;
    in_entry.ctrl.mem2reg    = e_mem2reg;
    in_entry.ctrl.ctrl_regwr = e_ctrl_regwr;
    in_entry.ctrl.memrd      = e_memrd;
    in_entry.ctrl.memwr      = e_memwr;
    in_entry.ctrl.branch     = e_branch;
    in_entry.br_taken        = e_branch & e_zero;
    in_entry.zero            = e_zero;
    in_entry.pc              = e_pc_out;
    in_entry.alu             = e_alu_out;
    in_entry.rd2             = e_read_data2;
    in_entry.wr_reg          = e_wr_reg;
  end

  pipe_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .s_tdata  (in_entry),
    .s_tvalid (e_valid),
    .s_tready (e_ready),
    .m_tdata  (main_entry),
    .m_tvalid (em_valid),
    .m_tready (m_ready)
  );

  // Unpack MAIN; control bits are gated by valid, data fields simply hold.
  always_comb begin
    ctrl_out      = gate_ctrl(main_entry.ctrl, em_valid);
    em_mem2reg    = ctrl_out.mem2reg;
    em_ctrl_regwr = ctrl_out.ctrl_regwr;
    em_memrd      = ctrl_out.memrd;
    em_memwr      = ctrl_out.memwr;
    em_branch     = ctrl_out.branch;
    em_br_taken   = main_entry.br_taken & em_valid;
    em_zero       = main_entry.zero;
    em_pc_out     = main_entry.pc;
    em_alu_out    = main_entry.alu;
    em_read_data2 = main_entry.rd2;
    em_wr_reg     = main_entry.wr_reg;
  end

`ifdef EXE_MEM_FWD_EN
  // EX-hazard bypass: only a register-writing ALU result with a non-zero destination may forward.
  always_comb begin
    em_fwd_en   = em_valid & em_ctrl_regwr & ~em_mem2reg & (em_wr_reg != '0);
    em_fwd_reg  = em_wr_reg;
    em_fwd_data = em_alu_out;
  end
`endif

endmodule

// File: tb/tb_exe_mem_stage.sv
// tb/tb_exe_mem_stage.sv - randomized queue-model bench for exe_mem_stage
module tb_exe_mem_stage;

  typedef struct packed {
    logic        mem2reg;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic        branch;
    logic        zero;
    logic [11:0] pc;
    logic [63:0] alu;
    logic [63:0] rd2;
    logic [5:0]  wr_reg;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic e_valid = 1'b0;
  logic m_ready = 1'b0;
  ent_t cur = '0;

  logic        e_ready;
  logic        em_valid;
  logic        em_mem2reg, em_ctrl_regwr, em_memrd, em_memwr, em_branch, em_zero, em_br_taken;
  logic [11:0] em_pc_out;
  logic [63:0] em_alu_out, em_read_data2;
  logic [5:0]  em_wr_reg;
`ifdef EXE_MEM_FWD_EN
  logic        em_fwd_en;
  logic [5:0]  em_fwd_reg;
  logic [63:0] em_fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ent_t q[$];
  ent_t last = '0;
  logic exp_ready = 1'b0;
  logic known = 1'b0;

  always #5 clk = ~clk;

  exe_mem_stage #(
    .DATA_W (64),
    .PC_W   (12),
    .REG_W  (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .e_valid       (e_valid),
    .e_ready       (e_ready),
    .e_mem2reg     (cur.mem2reg),
    .e_ctrl_regwr  (cur.regwr),
    .e_memrd       (cur.memrd),
    .e_memwr       (cur.memwr),
    .e_branch      (cur.branch),
    .e_zero        (cur.zero),
    .e_pc_out      (cur.pc),
    .e_alu_out     (cur.alu),
    .e_read_data2  (cur.rd2),
    .e_wr_reg      (cur.wr_reg),
    .em_valid      (em_valid),
    .m_ready       (m_ready),
    .em_mem2reg    (em_mem2reg),
    .em_ctrl_regwr (em_ctrl_regwr),
    .em_memrd      (em_memrd),
    .em_memwr      (em_memwr),
    .em_branch     (em_branch),
    .em_zero       (em_zero),
    .em_br_taken   (em_br_taken),
    .em_pc_out     (em_pc_out),
    .em_alu_out    (em_alu_out),
    .em_read_data2 (em_read_data2),
    .em_wr_reg     (em_wr_reg)
`ifdef EXE_MEM_FWD_EN
    ,
    .em_fwd_en     (em_fwd_en),
    .em_fwd_reg    (em_fwd_reg),
    .em_fwd_data   (em_fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.mem2reg = 1'($urandom);
    e.regwr   = 1'($urandom);
    e.memrd   = 1'($urandom);
    e.memwr   = 1'($urandom);
    e.branch  = 1'($urandom);
    e.zero    = 1'($urandom);
    e.pc      = 12'($urandom);
    e.alu     = {$urandom, $urandom};
    e.rd2     = {$urandom, $urandom};
    e.wr_reg  = 6'($urandom);
    return e;
  endfunction

  // One clock: compare outputs with the model at the falling edge, then advance the model.
  task automatic step();
    ent_t f;
    logic v;
    logic inf;
    logic outf;
    @(negedge clk);
    if (known) begin
      v = (q.size() != 0);
      f = v ? q[0] : last;
      check("em_valid", 64'(em_valid), 64'(v));
      check("e_ready", 64'(e_ready), 64'(exp_ready));
      check("em_mem2reg", 64'(em_mem2reg), 64'(v & f.mem2reg));
      check("em_ctrl_regwr", 64'(em_ctrl_regwr), 64'(v & f.regwr));
      check("em_memrd", 64'(em_memrd), 64'(v & f.memrd));
      check("em_memwr", 64'(em_memwr), 64'(v & f.memwr));
      check("em_branch", 64'(em_branch), 64'(v & f.branch));
      check("em_br_taken", 64'(em_br_taken), 64'(v & f.branch & f.zero));
      check("em_zero", 64'(em_zero), 64'(f.zero));
      check("em_pc_out", 64'(em_pc_out), 64'(f.pc));
      check("em_alu_out", em_alu_out, f.alu);
      check("em_read_data2", em_read_data2, f.rd2);
      check("em_wr_reg", 64'(em_wr_reg), 64'(f.wr_reg));
`ifdef EXE_MEM_FWD_EN
      check("em_fwd_en", 64'(em_fwd_en), 64'(v & f.regwr & ~f.mem2reg & (f.wr_reg != 6'd0)));
      check("em_fwd_reg", 64'(em_fwd_reg), 64'(f.wr_reg));
      check("em_fwd_data", em_fwd_data, f.alu);
`endif
      if (v) last = q[0];
    end
    inf  = e_valid & exp_ready;
    outf = (q.size() != 0) & m_ready;
    if (rst) begin
      q.delete();
      exp_ready = 1'b0;
      last = '0;
      known = 1'b1;
    end else if (flush) begin
      q.delete();
      exp_ready = 1'b1;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(cur);
      exp_ready = (q.size() < 2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a valid input present.
    rst = 1'b1;
    e_valid = 1'b1;
    cur = rand_ent();
    repeat (4) step();
    rst = 1'b0;
    e_valid = 1'b0;
    repeat (2) step();

    // Back-to-back streaming.
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e_valid = 1'b1;
      cur = rand_ent();
      cur.alu = 64'h10 + 64'(i);
      step();
    end
    e_valid = 1'b0;
    repeat (2) step();

    // Stall mid-stream.
    for (int i = 0; i < 12; i++) begin
      e_valid = 1'b1;
      m_ready = !(i >= 2 && i < 6);
      cur = rand_ent();
      cur.alu = 64'h100 + 64'(i);
      step();
    end
    e_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) step();

    // Branch taken / not taken.
    e_valid = 1'b1;
    cur = rand_ent();
    cur.branch = 1'b1;
    cur.zero = 1'b1;
    cur.pc = 12'hABC;
    step();
    cur.zero = 1'b0;
    step();
    e_valid = 1'b0;
    repeat (2) step();

    // Fill both entries, then flush with a simultaneous input.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_valid = 1'b1;
      cur = rand_ent();
      cur.memwr = 1'b1;
      step();
    end
    flush = 1'b1;
    cur = rand_ent();
    step();
    flush = 1'b0;
    e_valid = 1'b0;
    m_ready = 1'b1;
    repeat (2) step();

    // Forwarding candidates: non-zero and zero destination.
    e_valid = 1'b1;
    cur = rand_ent();
    cur.regwr = 1'b1;
    cur.mem2reg = 1'b0;
    cur.wr_reg = 6'd5;
    cur.alu = 64'h42;
    step();
    cur.wr_reg = 6'd0;
    step();
    e_valid = 1'b0;
    repeat (2) step();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      flush   = ($urandom_range(0, 19) == 0);
      e_valid = 1'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      cur     = rand_ent();
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    e_valid = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
